// File: rtl/irq_ctrl_pkg.sv
// Shared register map, FSM state encodings and helpers for the interrupt controller.
package irq_ctrl_pkg;

   localparam int unsigned IDX_W = 3;

   localparam logic [2:0] ADDR_PENDING = 3'd0;
   localparam logic [2:0] ADDR_MASK    = 3'd1;
   localparam logic [2:0] ADDR_ACK     = 3'd2;
   localparam logic [2:0] ADDR_CLAIM   = 3'd3;
   localparam logic [2:0] ADDR_EOI     = 3'd4;
   localparam logic [2:0] ADDR_MODE    = 3'd5;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ASSERT  = 2'd1;
   localparam logic [1:0] ST_SERVICE = 2'd2;

   function automatic logic [7:0] idx_onehot(input logic [IDX_W-1:0] idx);
      logic [7:0] oh;
      oh      = 8'd0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder; valid is high when any request is set.
module irq_prio_enc
   import irq_ctrl_pkg::*;
#(
   parameter int NSRC = 8
) (
   input  logic [NSRC-1:0]  req,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      idx   = 3'd0;
      valid = 1'b0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         idx   = req[i] ? 3'(i) : idx;
         valid = valid | req[i];
      end
   end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge/level pending capture, mask, lowest-index priority
// and a claim/EOI handshake that blocks nesting while a source is in service.
module irq_controller
   import irq_ctrl_pkg::*;
#(
   parameter int NSRC = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [NSRC-1:0] src_irq,
   output logic            irq,
   input  logic            s_cs_n,
   input  logic [2:0]      s_address,
   input  logic            s_read,
   output logic [31:0]     s_readdata,
   input  logic            s_write,
   input  logic [31:0]     s_writedata
);

   logic [NSRC-1:0]  pending_r;
   logic [NSRC-1:0]  prev_r;
   logic [NSRC-1:0]  mask_r;
   logic [NSRC-1:0]  mode_r;
   logic             armed_r;
   logic [IDX_W-1:0] in_service_r;
   logic [1:0]       state_r;
   logic             irq_r;

   logic [1:0]       state_nxt_s;
   logic             rd_s;
   logic             wr_s;
   logic             claim_s;
   logic             eoi_s;
   logic             any_s;
   logic [IDX_W-1:0] winner_s;
   logic [7:0]       claim_oh_s;
   logic [NSRC-1:0]  active_s;
   logic [NSRC-1:0]  edge_s;
   logic [NSRC-1:0]  clr_s;
   logic [NSRC-1:0]  pending_nxt_s;
   logic [31:0]      readdata_s;
   logic             unused_wdata_s;

   assign rd_s       = ~s_cs_n & s_read;
   assign wr_s       = ~s_cs_n & s_write;
   assign active_s   = pending_r & mask_r;
   assign claim_s    = rd_s & (s_address == ADDR_CLAIM) & (state_r == ST_ASSERT) & any_s;
   assign eoi_s      = wr_s & (s_address == ADDR_EOI) & (s_writedata[2:0] == in_service_r);
   assign claim_oh_s = idx_onehot(winner_s);
   // armed_r masks the first cycle after reset, when prev_r does not yet hold real history.
   assign edge_s     = src_irq & ~prev_r & {NSRC{armed_r}};
   assign unused_wdata_s = ^s_writedata[31:NSRC];

   irq_prio_enc #(.NSRC(NSRC)) u_prio_enc (
      .req   (active_s),
      .idx   (winner_s),
      .valid (any_s)
   );

   // Pending update: edge bits set-dominant over clears, level bits follow the source.
   always_comb begin
      if (wr_s && (s_address == ADDR_ACK)) begin
         clr_s = s_writedata[NSRC-1:0];
      end else begin
         clr_s = {NSRC{1'b0}};
      end
      if (claim_s) begin
         clr_s = clr_s | claim_oh_s[NSRC-1:0];
      end else begin
         clr_s = clr_s;
      end
      pending_nxt_s = (mode_r & (edge_s | (pending_r & ~clr_s))) | (~mode_r & src_irq);
   end

   // Claim/service handshake state machine.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (any_s) state_nxt_s = ST_ASSERT;
            else       state_nxt_s = ST_IDLE;
         end
         ST_ASSERT: begin
            if (claim_s)     state_nxt_s = ST_SERVICE;
            else if (!any_s) state_nxt_s = ST_IDLE;
            else             state_nxt_s = ST_ASSERT;
         end
         ST_SERVICE: begin
            if (eoi_s) state_nxt_s = ST_IDLE;
            else       state_nxt_s = ST_SERVICE;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Zero-wait-state register read decode.
   always_comb begin
      readdata_s = 32'd0;
      case (s_address)
         ADDR_PENDING: readdata_s[NSRC-1:0] = pending_r;
         ADDR_MASK:    readdata_s[NSRC-1:0] = mask_r;
         ADDR_MODE:    readdata_s[NSRC-1:0] = mode_r;
         ADDR_CLAIM: begin
            if ((state_r == ST_ASSERT) && any_s) readdata_s = {1'b1, 28'd0, winner_s};
            else                                 readdata_s = 32'd0;
         end
         default: readdata_s = 32'd0;
      endcase
   end

   assign s_readdata = readdata_s;
   assign irq        = irq_r;

   // State registers; irq mirrors the next state so it is high exactly in ASSERT.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pending_r    <= {NSRC{1'b0}};
         prev_r       <= {NSRC{1'b0}};
         mask_r       <= {NSRC{1'b0}};
         mode_r       <= {NSRC{1'b0}};
         armed_r      <= 1'b0;
         in_service_r <= 3'd0;
         state_r      <= ST_IDLE;
         irq_r        <= 1'b0;
      end else begin
         pending_r <= pending_nxt_s;
         prev_r    <= src_irq;
         armed_r   <= 1'b1;
         if (wr_s && (s_address == ADDR_MASK)) mask_r <= s_writedata[NSRC-1:0];
         if (wr_s && (s_address == ADDR_MODE)) mode_r <= s_writedata[NSRC-1:0];
         if (claim_s) in_service_r <= winner_s;
         state_r <= state_nxt_s;
         irq_r   <= (state_nxt_s == ST_ASSERT);
      end
   end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench: behavioural model of the controller plus directed literal checks.
module tb_irq_controller;

   localparam int NSRC = 8;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  src_irq;
   logic        irq;
   logic        s_cs_n;
   logic [2:0]  s_address;
   logic        s_read;
   logic [31:0] s_readdata;
   logic        s_write;
   logic [31:0] s_writedata;

   int vectors     = 0;
   int miscompares = 0;

   // Model: pending/mask/mode bytes, source history, whether irq is raised, and
   // which source (if any, -1 = none) the CPU is currently servicing.
   bit [7:0] m_pend, m_msk, m_mde, m_prev;
   bit       m_armed, m_raised, m_valid;
   int       m_serv;

   irq_controller #(.NSRC(NSRC)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .src_irq     (src_irq),
      .irq         (irq),
      .s_cs_n      (s_cs_n),
      .s_address   (s_address),
      .s_read      (s_read),
      .s_readdata  (s_readdata),
      .s_write     (s_write),
      .s_writedata (s_writedata)
   );

   always #5 clk = ~clk;

   function automatic int lowest(input bit [7:0] v);
      for (int i = 0; i < 8; i++) begin
         if (v[i]) return i;
      end
      return 0;
   endfunction

   function automatic logic [31:0] exp_rd();
      bit [7:0] act;
      act = m_pend & m_msk;
      case (s_address)
         3'd0: return {24'd0, m_pend};
         3'd1: return {24'd0, m_msk};
         3'd3: return (m_raised && act != 8'd0) ? (32'h8000_0000 | 32'(lowest(act))) : 32'd0;
         3'd5: return {24'd0, m_mde};
         default: return 32'd0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit       rd, wr, claim;
      bit [7:0] act, clr, edges, npend;
      int       win;
      if (!reset_n) begin
         m_pend = 8'd0; m_msk = 8'd0; m_mde = 8'd0; m_prev = 8'd0;
         m_armed = 1'b0; m_raised = 1'b0; m_serv = -1; m_valid = 1'b1;
         return;
      end
      rd    = !s_cs_n && s_read;
      wr    = !s_cs_n && s_write;
      act   = m_pend & m_msk;
      win   = lowest(act);
      claim = rd && s_address == 3'd3 && m_raised && act != 8'd0;
      clr   = (wr && s_address == 3'd2) ? s_writedata[7:0] : 8'd0;
      if (claim) clr[win] = 1'b1;
      edges = m_armed ? (src_irq & ~m_prev) : 8'd0;
      for (int i = 0; i < 8; i++) begin
         npend[i] = m_mde[i] ? (edges[i] | (m_pend[i] & !clr[i])) : src_irq[i];
      end
      if (m_serv >= 0) begin
         if (wr && s_address == 3'd4 && int'(s_writedata[2:0]) == m_serv) m_serv = -1;
         m_raised = 1'b0;
      end else if (claim) begin
         m_serv   = win;
         m_raised = 1'b0;
      end else begin
         m_raised = (act != 8'd0);
      end
      if (wr && s_address == 3'd1) m_msk = s_writedata[7:0];
      if (wr && s_address == 3'd5) m_mde = s_writedata[7:0];
      m_pend  = npend;
      m_prev  = src_irq;
      m_armed = 1'b1;
   endtask

   // One clock: compare at the falling edge, advance the model at the rising edge.
   task automatic tick(input bit lit, input string name, input logic [31:0] lrd, input logic lirq);
      @(negedge clk);
      if (m_valid) begin
         chk("model_rd", s_readdata, exp_rd());
         chk("model_irq", {31'd0, irq}, {31'd0, m_raised});
      end
      if (lit) begin
         chk({name, "_rd"}, s_readdata, lrd);
         chk({name, "_irq"}, {31'd0, irq}, {31'd0, lirq});
      end
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic bus_idle();
      s_cs_n = 1'b1; s_read = 1'b0; s_write = 1'b0; s_writedata = 32'd0;
   endtask

   task automatic idle();
      tick(1'b0, "", 32'd0, 1'b0);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      s_cs_n = 1'b0; s_write = 1'b1; s_address = a; s_writedata = d;
      idle();
      bus_idle();
   endtask

   task automatic rd(input logic [2:0] a, input string name, input logic [31:0] lrd, input logic lirq);
      s_cs_n = 1'b0; s_read = 1'b1; s_address = a;
      tick(1'b1, name, lrd, lirq);
      bus_idle();
   endtask

   task automatic look(input logic [2:0] a, input string name, input logic [31:0] lrd, input logic lirq);
      s_address = a;
      tick(1'b1, name, lrd, lirq);
   endtask

   initial begin
      m_valid = 1'b0; m_serv = -1;
      reset_n = 1'b0; src_irq = 8'd0; s_address = 3'd0;
      bus_idle();
      idle(); idle();
      reset_n = 1'b1;
      for (int a = 0; a < 8; a++) look(3'(a), "reset_rd", 32'd0, 1'b0);

      // Single edge pulse on source 0.
      wr(3'd5, 32'h0000_00FF); wr(3'd1, 32'h0000_0001);
      src_irq = 8'h01; look(3'd0, "edge_pulse", 32'd0, 1'b0);
      src_irq = 8'h00; look(3'd0, "pending_vis", 32'h1, 1'b0);
      look(3'd0, "irq_assert", 32'h1, 1'b1);
      rd(3'd3, "claim0", 32'h8000_0000, 1'b1);
      look(3'd0, "after_claim0", 32'd0, 1'b0);
      wr(3'd4, 32'd0); idle();

      // Simultaneous edges on 5 and 2; wrong then right EOI.
      wr(3'd1, 32'h0000_00FF);
      src_irq = 8'h24; look(3'd0, "two_edge", 32'd0, 1'b0);
      src_irq = 8'h00; look(3'd0, "two_pend", 32'h24, 1'b0);
      look(3'd0, "two_irq", 32'h24, 1'b1);
      rd(3'd3, "claim2", 32'h8000_0002, 1'b1);
      look(3'd0, "svc2", 32'h20, 1'b0);
      wr(3'd4, 32'd3);
      look(3'd0, "eoi_bad_a", 32'h20, 1'b0);
      look(3'd0, "eoi_bad_b", 32'h20, 1'b0);
      rd(3'd3, "claim_in_svc", 32'd0, 1'b0);
      wr(3'd4, 32'd2);
      look(3'd0, "eoi_ok_a", 32'h20, 1'b0);
      look(3'd0, "eoi_ok_b", 32'h20, 1'b1);
      rd(3'd3, "claim5", 32'h8000_0005, 1'b1);
      wr(3'd4, 32'd5); idle();

      // ACK colliding with a fresh edge on the same bit.
      wr(3'd1, 32'd0);
      src_irq = 8'h01; idle();
      src_irq = 8'h00; look(3'd0, "p0_set", 32'h1, 1'b0);
      src_irq = 8'h01; wr(3'd2, 32'h1);
      src_irq = 8'h00; look(3'd0, "ack_vs_edge", 32'h1, 1'b0);
      wr(3'd2, 32'h1);
      look(3'd0, "ack_clears", 32'd0, 1'b0);

      // Level-mode source 1.
      wr(3'd5, 32'h0000_00FD); wr(3'd1, 32'h0000_0002);
      src_irq = 8'h02; look(3'd0, "lvl_load", 32'd0, 1'b0);
      look(3'd0, "lvl_pend", 32'h2, 1'b0);
      look(3'd0, "lvl_irq", 32'h2, 1'b1);
      wr(3'd2, 32'h2);
      look(3'd0, "lvl_ack_noeff", 32'h2, 1'b1);
      src_irq = 8'h00; look(3'd0, "lvl_drop_a", 32'h2, 1'b1);
      look(3'd0, "lvl_drop_b", 32'd0, 1'b1);
      look(3'd0, "lvl_drop_c", 32'd0, 1'b0);

      // Reset in the middle of ASSERT.
      wr(3'd5, 32'h0000_00FF); wr(3'd1, 32'h0000_0001);
      src_irq = 8'h01; idle();
      src_irq = 8'h00; idle();
      look(3'd0, "pre_rst", 32'h1, 1'b1);
      reset_n = 1'b0; look(3'd0, "in_rst", 32'h1, 1'b1);
      reset_n = 1'b1; look(3'd0, "post_rst_pend", 32'd0, 1'b0);
      look(3'd1, "post_rst_mask", 32'd0, 1'b0);

      // Randomized traffic against the model.
      for (int n = 0; n < 4000; n++) begin
         int r;
         r = $urandom_range(0, 99);
         src_irq = 8'($urandom) & 8'($urandom);
         reset_n = ($urandom_range(0, 599) != 0);
         bus_idle();
         s_address = 3'($urandom_range(0, 7));
         if (r < 20) begin
            s_cs_n = 1'b0; s_read = 1'b1;
            if (r < 12) s_address = 3'd3;
         end else if (r < 50) begin
            s_cs_n = 1'b0; s_write = 1'b1; s_writedata = $urandom;
            if (r < 32) begin
               s_address = 3'd4;
               if (m_serv >= 0 && r < 28) s_writedata[2:0] = 3'(m_serv);
            end
         end else if (r < 55) begin
            s_read = 1'b1; s_write = 1'b1; s_writedata = $urandom;
         end
         idle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have parameter NSRC, default 8, number of interrupt sources (1..8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port src_irq  input  NSRC  interrupt sources; bit i = source i; synchronous to clk.
REQ-005 SHALL have port irq  output  1  registered interrupt request to CPU.
REQ-006 SHALL have port s_cs_n  input  1  slave chip select, active-low.
REQ-007 SHALL have port s_address  input  3  word register index.
REQ-008 SHALL have port s_read  input  1  read strobe, qualified by ~s_cs_n.
REQ-009 SHALL have port s_readdata  output  32  read data, combinational decode of s_address, zero wait states.
REQ-010 SHALL have port s_write  input  1  write strobe, qualified by ~s_cs_n.
REQ-011 SHALL have port s_writedata  input  32  write data.

Function
REQ-012 SHALL map registers: 0 PENDING (RO), 1 MASK (RW), 2 ACK (WO, write-1-to-clear), 3 CLAIM (RO, side effect), 4 EOI (WO), 5 MODE (RW; bit i=1 edge, 0 level); unused bits and addresses 6-7 read 0, writes ignored.
REQ-013 SHALL, in edge mode, register src_irq once (prev) and set pending[i] on the cycle src_irq[i] & ~prev[i] is sampled; pending visible in PENDING one cycle later.
REQ-014 SHALL, in level mode, load pending[i] from src_irq[i] each cycle; ACK and CLAIM do not clear level bits.
REQ-015 SHALL give a set event priority over ACK or CLAIM clear of the same bit in the same cycle (bit stays 1).
REQ-016 SHALL compute active = pending & MASK and select the lowest set index as winner (index 0 highest priority).
REQ-017 SHALL implement FSM IDLE/ASSERT/SERVICE: IDLE->ASSERT when active != 0; ASSERT->IDLE if active becomes 0 before claim; ASSERT->SERVICE on CLAIM read.
REQ-018 SHALL drive irq registered: 1 exactly while state is ASSERT; assertion one cycle after active becomes non-zero.
REQ-019 SHALL return on CLAIM read bit31=valid (state ASSERT), bits[2:0]=winner; read in IDLE/SERVICE returns 0 with no side effect.
REQ-020 SHALL, on valid CLAIM read, latch winner into in_service and clear pending[winner] if edge mode.
REQ-021 SHALL, in SERVICE, hold irq low regardless of new pending bits (no nesting).
REQ-022 SHALL leave SERVICE for IDLE only on EOI write with s_writedata[2:0] == in_service; mismatched EOI ignored.
REQ-023 SHALL re-evaluate active in IDLE the cycle after EOI, so a queued source re-asserts irq two cycles after EOI write.
REQ-024 SHALL treat MASK change as immediate: clearing the only active bit in ASSERT returns FSM to IDLE and drops irq next cycle.

Reset
REQ-025 SHALL, on clk edge with reset_n low, set pending, prev, MASK, MODE, in_service to 0, FSM to IDLE, irq to 0; s_readdata reads 0 for all addresses while MASK/MODE are 0 and nothing pending.
REQ-026 SHALL abandon any in-progress claim/service on reset mid-operation; no pending state survives.
REQ-027 SHALL not detect an edge on the first cycle after reset release for a source already high (prev is loaded then).

Structure
REQ-028 SHALL place register address constants and FSM state encodings in shared package irq_ctrl_pkg.
REQ-029 SHALL use one sub-module irq_prio_enc (NSRC-wide lowest-index priority encoder with valid output).

Verification
REQ-030 SHALL check: MODE=0xFF, MASK=0x01, pulse src_irq[0] one cycle -> PENDING=0x01, irq=1 two cycles after pulse.
REQ-031 SHALL check: sources 5 and 2 edge same cycle, MASK=0xFF -> CLAIM reads 0x80000002, irq low; EOI 2 -> irq re-asserts, CLAIM reads 0x80000005.
REQ-032 SHALL check: in SERVICE(2), EOI write 3 -> state stays SERVICE, irq stays 0.
REQ-033 SHALL check: ACK 0x01 same cycle as new edge on source 0 -> PENDING bit0 remains 1.
REQ-034 SHALL check: level mode source 1 held high, MASK=0x02 -> ACK has no effect; drop source -> PENDING=0 next cycle, irq drops.
REQ-035 SHALL check: reset_n low for one cycle while in ASSERT -> irq=0, PENDING=0, MASK=0 next cycle.
